id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Issue/hazard controller at the ID stage. Tracks in-flight RegFile writers in EXE/MEM/WB
//  and per source operand selects the RF or EXE/MEM/WB bypass value. Stalls ID on load-use
//  and on consumers of a multi-cycle MDU (mul/div) op, and holds EXE while the MDU runs.
//  Sits beside the bypass network; drives ID operand muxes and the ID->EXE handshake.
// PARAMETERS
//  RF_AW    5  RegFile address width
//  MDU_LAT  4  cycles an MDU op occupies EXE (>=2)
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset         in   1      asynchronous, active-high reset
//  id_valid      in   1      ID holds a valid instruction
//  id_rs1_addr   in   RF_AW  source 1 address
//  id_rs1_ren    in   1      source 1 is read
//  id_rs2_addr   in   RF_AW  source 2 address
//  id_rs2_ren    in   1      source 2 is read
//  id_rd_addr    in   RF_AW  destination address
//  id_rf_w_en    in   1      instruction writes RegFile
//  id_is_load    in   1      load (data valid only from MEM onward)
//  id_is_mdu     in   1      multi-cycle MDU op (result valid at end of its last EXE cycle)
//  flush         in   1      kill instruction in ID this cycle (branch redirect)
//  id_ready_go   out  1      ID may issue this cycle
//  exe_hold      out  1      EXE (and everything older) frozen this cycle
//  rs1_fwd_sel   out  2      00 RF, 01 EXE, 10 MEM, 11 WB
//  rs2_fwd_sel   out  2      same encoding for source 2
//  mdu_busy      out  1      MDU FSM not IDLE
// BEHAVIOUR
//  - Slot regs EXE/MEM/WB each: {vld, rd, wen, ld, mdu}. Reset: all vld=0, FSM=IDLE,
//    counter=0 => id_ready_go=id_valid&~flush-dependent (comb), exe_hold=0, mdu_busy=0, sel=00.
//  - Advance: if exe_hold=0 then WB<=MEM, MEM<=EXE, EXE<=issue?ID fields:bubble(vld=0).
//    If exe_hold=1 then EXE/MEM/WB hold; WB is not re-written (WB retires once).
//  - issue = id_valid & id_ready_go & ~flush & ~exe_hold.
//  - Writer match for stage S on operand rsX: S.vld & S.wen & S.rd==rsX & rsX!=0 & rsX_ren.
//  - Forward priority EXE > MEM > WB > RF (youngest wins). rsX==0 always sel 00, never stalls.
//  - Stall (id_ready_go=0) if any read operand matches EXE with EXE.ld=1 (load-use, 1 bubble),
//    or EXE.mdu=1 and FSM!=DONE, or exe_hold=1. Otherwise id_ready_go=id_valid.
//  - fwd_sel is valid every cycle regardless of stall (combinational from current slots).
//  - MDU FSM: IDLE -> RUN when EXE.vld&EXE.mdu (load counter MDU_LAT-2);
//    RUN: counter-- each cycle, exe_hold=1; counter==0 -> DONE; DONE: exe_hold=0,
//    result forwardable from EXE this cycle, next cycle -> IDLE (or RUN if a new MDU op
//    entered EXE). An MDU op therefore holds EXE exactly MDU_LAT cycles total.
//  - Back-to-back MDU ops: second enters EXE on DONE->advance; FSM goes DONE->RUN directly.
//  - flush: suppresses issue only; never alters slots or FSM (older instructions unaffected).
//  - flush and stall in same cycle: bubble enters EXE, no double count.
//  - reset asserted mid-MDU: FSM to IDLE, counter 0, all slots invalid, asynchronously.
//  - Simultaneous id_rs1==id_rs2: both sels identical; one stall decision.
// TESTING
//  1 add r3 in EXE, add in ID reads r3,r3 -> rs1_fwd_sel=rs2_fwd_sel=01, id_ready_go=1.
//  2 ld r5 issues, next ID reads r5 -> id_ready_go=0 one cycle, then sel=10 and issue.
//  3 r7 writers in EXE and WB, ID reads r7 -> sel=01 (EXE priority); r0 read -> sel=00.
//  4 MDU_LAT=4 div r9, dependent on r9 in ID -> exe_hold=1 cycles 1-3, issue in cycle 4, sel=01.
//  5 reset pulsed during RUN -> mdu_busy=0, exe_hold=0, sels 00 immediately (async).
//  6 flush with id_valid=1, no hazard -> EXE.vld=0 next cycle, MEM/WB advance normally.

Source files
------------

// File: rtl/id_issue_if.sv
// ID-stage issue handshake: operand/destination info from ID, and the
// controller's issue, hold and bypass-select decisions back to it.
interface id_issue_if #(
  parameter int unsigned RF_AW = 5
);
  logic             id_valid;
  logic [RF_AW-1:0] id_rs1_addr;
  logic             id_rs1_ren;
  logic [RF_AW-1:0] id_rs2_addr;
  logic             id_rs2_ren;
  logic [RF_AW-1:0] id_rd_addr;
  logic             id_rf_w_en;
  logic             id_is_load;
  logic             id_is_mdu;
  logic             flush;
  logic             id_ready_go;
  logic             exe_hold;
  logic [1:0]       rs1_fwd_sel;
  logic [1:0]       rs2_fwd_sel;
  logic             mdu_busy;

  modport master (
    output id_valid, id_rs1_addr, id_rs1_ren, id_rs2_addr, id_rs2_ren,
           id_rd_addr, id_rf_w_en, id_is_load, id_is_mdu, flush,
    input  id_ready_go, exe_hold, rs1_fwd_sel, rs2_fwd_sel, mdu_busy
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs1_ren, id_rs2_addr, id_rs2_ren,
           id_rd_addr, id_rf_w_en, id_is_load, id_is_mdu, flush,
    output id_ready_go, exe_hold, rs1_fwd_sel, rs2_fwd_sel, mdu_busy
  );
endinterface

// File: rtl/id_issue_ctrl.sv
// ID-stage issue/hazard controller: tracks RegFile writers in EXE/MEM/WB,
// picks bypass sources, stalls on load-use and MDU consumers, and freezes
// EXE while a multi-cycle MDU op runs.
module id_issue_ctrl #(
  parameter int unsigned RF_AW   = 5,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  id_issue_if.slave  bus
);

  localparam int unsigned CW = $clog2(MDU_LAT);

  typedef struct packed {
    logic             vld;
    logic [RF_AW-1:0] rd;
    logic             wen;
    logic             ld;
    logic             mdu;
  } slot_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mdu_state_t;

  slot_t      exe_q, mem_q, wb_q, id_slot;
  mdu_state_t state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx, cnt_dec;
  logic exe_hold_i, issue, dep_exe, stall;
  logic rs1_e, rs1_m, rs1_w, rs2_e, rs2_m, rs2_w;
  logic unused_bits;

  // ld/mdu only matter while the instruction sits in EXE
  assign unused_bits = ^{mem_q.ld, mem_q.mdu, wb_q.ld, wb_q.mdu};

  function automatic logic hit(slot_t s, logic [RF_AW-1:0] a, logic ren);
    return s.vld && s.wen && (s.rd == a) && (a != '0) && ren;
  endfunction

  // Writer matches per operand and stage, bypass selection and issue decision
  always_comb begin
    rs1_e = hit(exe_q, bus.id_rs1_addr, bus.id_rs1_ren);
    rs1_m = hit(mem_q, bus.id_rs1_addr, bus.id_rs1_ren);
    rs1_w = hit(wb_q,  bus.id_rs1_addr, bus.id_rs1_ren);
    rs2_e = hit(exe_q, bus.id_rs2_addr, bus.id_rs2_ren);
    rs2_m = hit(mem_q, bus.id_rs2_addr, bus.id_rs2_ren);
    rs2_w = hit(wb_q,  bus.id_rs2_addr, bus.id_rs2_ren);

    bus.rs1_fwd_sel = rs1_e ? 2'b01 : rs1_m ? 2'b10 : rs1_w ? 2'b11 : 2'b00;
    bus.rs2_fwd_sel = rs2_e ? 2'b01 : rs2_m ? 2'b10 : rs2_w ? 2'b11 : 2'b00;

    dep_exe = rs1_e || rs2_e;
    stall   = (dep_exe && exe_q.ld)
           || (dep_exe && exe_q.mdu && (state_q != S_DONE))
           || exe_hold_i;
    bus.id_ready_go = bus.id_valid && !stall;
    issue = bus.id_ready_go && !bus.flush && !exe_hold_i;

    id_slot     = '0;
    id_slot.vld = 1'b1;
    id_slot.rd  = bus.id_rd_addr;
    id_slot.wen = bus.id_rf_w_en;
    id_slot.ld  = bus.id_is_load;
    id_slot.mdu = bus.id_is_mdu;
  end

  // Pipeline slots advance together unless EXE is frozen by the MDU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!exe_hold_i) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= issue ? id_slot : '0;
    end
  end

  // MDU FSM state and cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // MDU next state: an op spends one cycle in IDLE (or enters directly into
  // RUN when following another op), MDU_LAT-2 cycles in RUN, then one in DONE.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    cnt_dec  = cnt_q - CW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (exe_q.vld && exe_q.mdu) begin
          if (MDU_LAT > 2) begin
            state_nx = S_RUN;
            cnt_nx   = CW'(MDU_LAT - 2);
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_RUN: begin
        cnt_nx = cnt_dec;
        if (cnt_dec == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        // Back-to-back op skips the IDLE cycle, so its RUN phase is one longer
        if (issue && bus.id_is_mdu) begin
          state_nx = S_RUN;
          cnt_nx   = CW'(MDU_LAT - 1);
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // MDU outputs: hold EXE until the op's final (DONE) cycle
  always_comb begin
    exe_hold_i   = exe_q.vld && exe_q.mdu && (state_q != S_DONE);
    bus.exe_hold = exe_hold_i;
    bus.mdu_busy = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed vector table, async reset sequence,
// and randomized traffic against a behavioural pipeline model.
module tb_id_issue_ctrl;
  localparam int unsigned RF_AW   = 5;
  localparam int unsigned MDU_LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_issue_if #(.RF_AW(RF_AW)) bus ();

  id_issue_ctrl #(.RF_AW(RF_AW), .MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit valid; int rs1; bit ren1; int rs2; bit ren2;
    int rd; bit wen; bit ld; bit mdu; bit flush;
  } id_t;

  typedef struct {
    bit rst;
    id_t in;
    logic [6:0] exp;   // {ready_go, exe_hold, rs1_sel, rs2_sel, mdu_busy}
  } vec_t;

  typedef struct { bit vld; int rd; bit wen; bit ld; bit mdu; } mslot_t;

  int n_pass = 0;
  int n_total = 0;

  mslot_t m_exe, m_mem, m_wb;
  int m_age;
  bit m_prev_rel;

  function automatic id_t mk(bit v, int r1, bit e1, int r2, bit e2,
                             int rd, bit w, bit l, bit m, bit f);
    id_t x;
    x.valid = v; x.rs1 = r1; x.ren1 = e1; x.rs2 = r2; x.ren2 = e2;
    x.rd = rd; x.wen = w; x.ld = l; x.mdu = m; x.flush = f;
    return x;
  endfunction

  function automatic vec_t vr(bit rst, id_t x, bit r, bit h, int s1, int s2, bit b);
    vec_t v;
    v.rst = rst; v.in = x;
    v.exp = {r, h, 2'(s1), 2'(s2), b};
    return v;
  endfunction

  task automatic drive(input id_t x);
    bus.id_valid    = x.valid;
    bus.id_rs1_addr = RF_AW'(x.rs1);
    bus.id_rs1_ren  = x.ren1;
    bus.id_rs2_addr = RF_AW'(x.rs2);
    bus.id_rs2_ren  = x.ren2;
    bus.id_rd_addr  = RF_AW'(x.rd);
    bus.id_rf_w_en  = x.wen;
    bus.id_is_load  = x.ld;
    bus.id_is_mdu   = x.mdu;
    bus.flush       = x.flush;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {bus.id_ready_go, bus.exe_hold, bus.rs1_fwd_sel, bus.rs2_fwd_sel, bus.mdu_busy};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {rdy,hold,s1,s2,busy}=%b required %b at %0t", name, got, exp, $time);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  // Behavioural model: instructions flow through a 3-entry pipeline; an MDU
  // op in EXE stays there for MDU_LAT cycles (age 0 .. MDU_LAT-1).
  function automatic void m_clear();
    m_exe = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
    m_age = 0; m_prev_rel = 0;
  endfunction

  function automatic bit m_hit(mslot_t s, int a, bit ren);
    return s.vld && s.wen && (s.rd == a) && (a != 0) && ren;
  endfunction

  function automatic int m_sel(int a, bit ren);
    if (m_hit(m_exe, a, ren)) return 1;
    if (m_hit(m_mem, a, ren)) return 2;
    if (m_hit(m_wb, a, ren))  return 3;
    return 0;
  endfunction

  function automatic void m_eval(input id_t x, output logic [6:0] e, output bit iss, output bit hold);
    bit mdu_in, busy, dep, stall, rdy;
    mdu_in = m_exe.vld && m_exe.mdu;
    hold   = mdu_in && (m_age < int'(MDU_LAT) - 1);
    busy   = mdu_in && (m_age > 0 || m_prev_rel);
    dep    = m_hit(m_exe, x.rs1, x.ren1) || m_hit(m_exe, x.rs2, x.ren2);
    stall  = (dep && m_exe.ld) || (dep && hold) || hold;
    rdy    = x.valid && !stall;
    iss    = rdy && !x.flush && !hold;
    e = {rdy, hold, 2'(m_sel(x.rs1, x.ren1)), 2'(m_sel(x.rs2, x.ren2)), busy};
  endfunction

  function automatic void m_step(input id_t x, input bit iss, input bit hold);
    bit rel;
    rel = m_exe.vld && m_exe.mdu && (m_age == int'(MDU_LAT) - 1);
    if (!hold) begin
      m_wb  = m_mem;
      m_mem = m_exe;
      if (iss) begin
        m_exe.vld = 1; m_exe.rd = x.rd; m_exe.wen = x.wen; m_exe.ld = x.ld; m_exe.mdu = x.mdu;
      end else begin
        m_exe = '{default: 0};
      end
      m_age = 0;
    end else begin
      m_age++;
    end
    m_prev_rel = rel;
  endfunction

  vec_t tbl[$];
  id_t  idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Forwarding, load-use, priority, r0 and flush
    tbl.push_back(vr(1, mk(1, 0,0, 0,0,  3,1,0,0,0), 1,0,0,0,0));
    tbl.push_back(vr(0, mk(1, 3,1, 3,1,  4,1,0,0,0), 1,0,1,1,0));
    tbl.push_back(vr(0, mk(1, 0,1, 0,0,  5,1,1,0,0), 1,0,0,0,0));
    tbl.push_back(vr(0, mk(1, 5,1, 6,0,  6,1,0,0,0), 0,0,1,0,0));
    tbl.push_back(vr(0, mk(1, 5,1, 6,0,  6,1,0,0,0), 1,0,2,0,0));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0,  7,1,0,0,0), 1,0,0,0,0));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0,  8,1,0,0,0), 1,0,0,0,0));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0,  7,1,0,0,0), 1,0,0,0,0));
    tbl.push_back(vr(0, mk(1, 7,1, 0,1,  9,1,0,0,0), 1,0,1,0,0));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0, 10,1,0,0,1), 1,0,0,0,0));
    tbl.push_back(vr(0, mk(0,10,1, 9,1,  0,0,0,0,0), 0,0,0,2,0));
    tbl.push_back(vr(0, mk(0, 9,1, 8,1,  0,0,0,0,0), 0,0,3,0,0));
    // MDU hold, dependent issue, back-to-back MDU
    tbl.push_back(vr(1, mk(1, 0,0, 0,0,  9,1,0,1,0), 1,0,0,0,0));
    tbl.push_back(vr(0, mk(1, 9,1, 0,0, 10,1,0,0,0), 0,1,1,0,0));
    tbl.push_back(vr(0, mk(1, 9,1, 0,0, 10,1,0,0,0), 0,1,1,0,1));
    tbl.push_back(vr(0, mk(1, 9,1, 0,0, 10,1,0,0,0), 0,1,1,0,1));
    tbl.push_back(vr(0, mk(1, 9,1, 0,0, 10,1,0,0,0), 1,0,1,0,1));
    tbl.push_back(vr(0, mk(1,10,1, 0,0, 11,1,0,1,0), 1,0,1,0,0));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0, 12,1,0,1,0), 0,1,0,0,0));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0, 12,1,0,1,0), 0,1,0,0,1));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0, 12,1,0,1,0), 0,1,0,0,1));
    tbl.push_back(vr(0, mk(1, 0,0, 0,0, 12,1,0,1,0), 1,0,0,0,1));
    tbl.push_back(vr(0, mk(0,12,1, 0,0,  0,0,0,0,0), 0,1,1,0,1));
    tbl.push_back(vr(0, mk(0,12,1, 0,0,  0,0,0,0,0), 0,1,1,0,1));
    tbl.push_back(vr(0, mk(0,12,1, 0,0,  0,0,0,0,0), 0,1,1,0,1));
    tbl.push_back(vr(0, mk(0,12,1, 0,0,  0,0,0,0,0), 0,0,1,0,1));
    tbl.push_back(vr(0, mk(0,12,1, 0,0,  0,0,0,0,0), 0,0,2,0,0));

    drive(idle);
    #12;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state with an instruction reading a nonzero register
    drive(mk(1, 4,1, 5,1, 6,1,0,0,0));
    #2;
    check("reset_state", {1'b1, 1'b0, 2'b00, 2'b00, 1'b0});
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      drive(tbl[i].in);
      #2;
      check($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge clk); #1;
    end

    // Asynchronous reset while the MDU is running
    pulse_reset();
    drive(mk(1, 0,0, 0,0, 9,1,0,1,0));
    @(posedge clk); #1;
    drive(mk(0, 9,1, 9,1, 0,0,0,0,0));
    @(posedge clk); #1;
    #2;
    check("mdu_running", {1'b0, 1'b1, 2'b01, 2'b01, 1'b1});
    reset = 1'b1;
    #1;
    check("async_reset", {1'b0, 1'b0, 2'b00, 2'b00, 1'b0});
    reset = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the model
    pulse_reset();
    m_clear();
    for (int c = 0; c < 3000; c++) begin
      id_t x;
      logic [6:0] e;
      bit iss, hold;
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
        m_clear();
      end
      x.valid = ($urandom_range(0, 9) < 8);
      x.rs1   = int'($urandom_range(0, 3));
      x.ren1  = $urandom_range(0, 3) != 0;
      x.rs2   = int'($urandom_range(0, 3));
      x.ren2  = $urandom_range(0, 1) != 0;
      x.rd    = int'($urandom_range(0, 3));
      x.wen   = ($urandom_range(0, 9) < 7);
      x.ld    = ($urandom_range(0, 99) < 15);
      x.mdu   = !x.ld && ($urandom_range(0, 99) < 10);
      x.flush = ($urandom_range(0, 9) == 0);
      drive(x);
      #2;
      m_eval(x, e, iss, hold);
      check($sformatf("rand%0d", c), e);
      m_step(x, iss, hold);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
